// File: rtl/bip_pkg.sv
// ---------------------------------------------------------------------------
// bip_pkg
// Shared definitions for the BIP fetch/control slice:
//   - instruction field widths (opcode, operand, full word)
//   - opcode constants OP_HLT .. OP_SUBI
//   - accumulator input select encodings
//   - packed control vector driven towards the datapath
//   - FSM state encoding used by bip_fetch_control
// ---------------------------------------------------------------------------
package bip_pkg;

    localparam int OPC_W   = 5;
    localparam int OPD_W   = 11;
    localparam int INSTR_W = 16;

    localparam logic [OPC_W-1:0] OP_HLT  = 5'd0;
    localparam logic [OPC_W-1:0] OP_STO  = 5'd1;
    localparam logic [OPC_W-1:0] OP_LD   = 5'd2;
    localparam logic [OPC_W-1:0] OP_LDI  = 5'd3;
    localparam logic [OPC_W-1:0] OP_ADD  = 5'd4;
    localparam logic [OPC_W-1:0] OP_ADDI = 5'd5;
    localparam logic [OPC_W-1:0] OP_SUB  = 5'd6;
    localparam logic [OPC_W-1:0] OP_SUBI = 5'd7;

    localparam logic [1:0] SELA_RAM = 2'b00;
    localparam logic [1:0] SELA_IMM = 2'b01;
    localparam logic [1:0] SELA_ALU = 2'b10;

    // Datapath control strobes for one EXEC cycle.
    typedef struct packed {
        logic [1:0] sel_a;
        logic       sel_b;
        logic       alu_op;
        logic       wr_acc;
        logic       wr_ram;
        logic       rd_ram;
    } ctrl_t;

    localparam ctrl_t CTRL_IDLE = '0;

    typedef enum logic [1:0] {
        ST_FETCH = 2'd0,
        ST_EXEC  = 2'd1,
        ST_HALT  = 2'd2
    } state_e;

endpackage

// File: rtl/bip_decoder.sv
// ---------------------------------------------------------------------------
// bip_decoder
// Purely combinational opcode decoder for the BIP instruction set.
// Ports:
//   opcode_i   in   OPC_W   opcode field of the current instruction word
//   ctrl_o     out  ctrl_t  datapath control vector for that opcode
//   illegal_o  out  1       opcode is not part of the instruction set
//   is_hlt_o   out  1       opcode is HLT
// ---------------------------------------------------------------------------
module bip_decoder
    import bip_pkg::*;
(
    input  logic [OPC_W-1:0] opcode_i,
    output ctrl_t            ctrl_o,
    output logic             illegal_o,
    output logic             is_hlt_o
);

    always_comb begin
        ctrl_o    = CTRL_IDLE;
        illegal_o = 1'b0;
        is_hlt_o  = 1'b0;
        unique case (opcode_i)
            OP_HLT: begin
                is_hlt_o = 1'b1;
            end
            OP_STO: begin
                ctrl_o.wr_ram = 1'b1;
            end
            OP_LD: begin
                ctrl_o.sel_a  = SELA_RAM;
                ctrl_o.rd_ram = 1'b1;
                ctrl_o.wr_acc = 1'b1;
            end
            OP_LDI: begin
                ctrl_o.sel_a  = SELA_IMM;
                ctrl_o.wr_acc = 1'b1;
            end
            OP_ADD: begin
                ctrl_o.sel_a  = SELA_ALU;
                ctrl_o.sel_b  = 1'b0;
                ctrl_o.alu_op = 1'b0;
                ctrl_o.rd_ram = 1'b1;
                ctrl_o.wr_acc = 1'b1;
            end
            OP_ADDI: begin
                ctrl_o.sel_a  = SELA_ALU;
                ctrl_o.sel_b  = 1'b1;
                ctrl_o.alu_op = 1'b0;
                ctrl_o.wr_acc = 1'b1;
            end
            OP_SUB: begin
                ctrl_o.sel_a  = SELA_ALU;
                ctrl_o.sel_b  = 1'b0;
                ctrl_o.alu_op = 1'b1;
                ctrl_o.rd_ram = 1'b1;
                ctrl_o.wr_acc = 1'b1;
            end
            OP_SUBI: begin
                ctrl_o.sel_a  = SELA_ALU;
                ctrl_o.sel_b  = 1'b1;
                ctrl_o.alu_op = 1'b1;
                ctrl_o.wr_acc = 1'b1;
            end
            default: begin
                // Undefined opcodes behave as a NOP that is flagged.
                illegal_o = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/bip_fetch_control.sv
// ---------------------------------------------------------------------------
// bip_fetch_control
// Instruction fetch and control unit of the BIP processor. Owns the program
// counter, sequences FETCH/EXEC with a registered-read program memory and
// turns each instruction into single-cycle datapath strobes. HLT parks the
// machine in HALT until reset.
// Ports:
//   clk_i       in   1       system clock, rising edge
//   rst_ni      in   1       asynchronous active-low reset
//   enable_i    in   1       low freezes FSM/PC and forces strobes low
//   pm_addr_o   out  OPD_W   program memory address (the PC)
//   pm_data_i   in   INSTR_W instruction word, valid one cycle after address
//   operand_o   out  OPD_W   instruction operand (RAM address / immediate)
//   sel_a_o     out  2       accumulator input select
//   sel_b_o     out  1       ALU B operand select
//   alu_op_o    out  1       0 add, 1 subtract
//   wr_acc_o    out  1       accumulator write strobe
//   wr_ram_o    out  1       data RAM write strobe
//   rd_ram_o    out  1       data RAM read strobe
//   illegal_o   out  1       pulse on an undefined opcode
//   halted_o    out  1       high while halted
// ---------------------------------------------------------------------------
module bip_fetch_control
    import bip_pkg::*;
#(
    parameter int unsigned PROG_DEPTH = 2048
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic               enable_i,
    output logic [OPD_W-1:0]   pm_addr_o,
    input  logic [INSTR_W-1:0] pm_data_i,
    output logic [OPD_W-1:0]   operand_o,
    output logic [1:0]         sel_a_o,
    output logic               sel_b_o,
    output logic               alu_op_o,
    output logic               wr_acc_o,
    output logic               wr_ram_o,
    output logic               rd_ram_o,
    output logic               illegal_o,
    output logic               halted_o
);

    // PROG_DEPTH is a power of two, so wrapping is a mask of the low bits.
    localparam logic [OPD_W-1:0] PC_MASK = OPD_W'(PROG_DEPTH - 1);

    state_e            state_q, state_d;
    logic [OPD_W-1:0]  pc_q, pc_d;

    ctrl_t             dec_ctrl;
    logic              dec_illegal;
    logic              dec_is_hlt;
    ctrl_t             ctrl;
    logic              exec_active;

    bip_decoder u_decoder (
        .opcode_i  (pm_data_i[INSTR_W-1:OPD_W]),
        .ctrl_o    (dec_ctrl),
        .illegal_o (dec_illegal),
        .is_hlt_o  (dec_is_hlt)
    );

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= ST_FETCH;
            pc_q    <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
        end
    end

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        if (enable_i) begin
            unique case (state_q)
                ST_FETCH: begin
                    state_d = ST_EXEC;
                end
                ST_EXEC: begin
                    if (dec_is_hlt) begin
                        state_d = ST_HALT;
                    end else begin
                        state_d = ST_FETCH;
                        pc_d    = (pc_q + OPD_W'(1)) & PC_MASK;
                    end
                end
                ST_HALT: begin
                    state_d = ST_HALT;
                end
                default: begin
                    state_d = ST_FETCH;
                end
            endcase
        end
    end

    // Strobes exist only in an enabled EXEC cycle; a stalled EXEC keeps
    // the word on the bus, so it fires once when enable returns.
    assign exec_active = (state_q == ST_EXEC) && enable_i;

    always_comb begin
        ctrl      = CTRL_IDLE;
        illegal_o = 1'b0;
        if (exec_active) begin
            ctrl      = dec_ctrl;
            illegal_o = dec_illegal;
        end
    end

    assign pm_addr_o = pc_q;
    assign operand_o = pm_data_i[OPD_W-1:0];
    assign sel_a_o   = ctrl.sel_a;
    assign sel_b_o   = ctrl.sel_b;
    assign alu_op_o  = ctrl.alu_op;
    assign wr_acc_o  = ctrl.wr_acc;
    assign wr_ram_o  = ctrl.wr_ram;
    assign rd_ram_o  = ctrl.rd_ram;
    assign halted_o  = (state_q == ST_HALT);

endmodule

// File: tb/tb_bip_fetch_control.sv
// ---------------------------------------------------------------------------
// tb_bip_fetch_control
// Bench for bip_fetch_control. A registered-read program memory feeds the
// main instance (PROG_DEPTH=2048); a second instance with PROG_DEPTH=4 runs
// a HLT-free program to show PC wrap. An instruction-level model tracks PC,
// fetch/execute phase and halt and is compared against the main instance on
// every falling edge, alongside hand-computed directed expectations.
// ---------------------------------------------------------------------------
module tb_bip_fetch_control;
    import bip_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        enable = 1'b1;

    logic [15:0] mem [0:2047];
    logic [15:0] pm_data;
    logic [10:0] pm_addr, operand;
    logic [1:0]  sel_a;
    logic        sel_b, alu_op, wr_acc, wr_ram, rd_ram, illegal, halted;

    logic [15:0] mem2 [0:3];
    logic [15:0] pm_data2;
    logic [10:0] pm_addr2, operand2;
    logic [1:0]  sel_a2;
    logic        sel_b2, alu_op2, wr_acc2, wr_ram2, rd_ram2, illegal2, halted2;
    logic        enable2 = 1'b1;

    int          compared = 0;
    int          mismatched = 0;

    int          modelPc = 0;
    bit          modelExec = 1'b0;
    bit          modelHalted = 1'b0;
    logic [7:0]  modelCtrl;

    always #5 clk = ~clk;

    bip_fetch_control #(.PROG_DEPTH(2048)) dut (
        .clk_i     (clk),
        .rst_ni    (rst_n),
        .enable_i  (enable),
        .pm_addr_o (pm_addr),
        .pm_data_i (pm_data),
        .operand_o (operand),
        .sel_a_o   (sel_a),
        .sel_b_o   (sel_b),
        .alu_op_o  (alu_op),
        .wr_acc_o  (wr_acc),
        .wr_ram_o  (wr_ram),
        .rd_ram_o  (rd_ram),
        .illegal_o (illegal),
        .halted_o  (halted)
    );

    bip_fetch_control #(.PROG_DEPTH(4)) dutWrap (
        .clk_i     (clk),
        .rst_ni    (rst_n),
        .enable_i  (enable2),
        .pm_addr_o (pm_addr2),
        .pm_data_i (pm_data2),
        .operand_o (operand2),
        .sel_a_o   (sel_a2),
        .sel_b_o   (sel_b2),
        .alu_op_o  (alu_op2),
        .wr_acc_o  (wr_acc2),
        .wr_ram_o  (wr_ram2),
        .rd_ram_o  (rd_ram2),
        .illegal_o (illegal2),
        .halted_o  (halted2)
    );

    // Registered-read program memories: one cycle address-to-data.
    always @(posedge clk) begin
        pm_data  <= mem[pm_addr];
        pm_data2 <= mem2[pm_addr2[1:0]];
    end

    function automatic logic [15:0] ins(input logic [4:0] opc, input int opd);
        return {opc, 11'(opd)};
    endfunction

    // Control vector packed as {sel_a, sel_b, alu_op, wr_acc, wr_ram, rd_ram, illegal}.
    function automatic logic [7:0] expCtrl(input logic [4:0] opc);
        case (opc)
            5'd0:    return 8'b00_0_0_0_0_0_0;
            5'd1:    return 8'b00_0_0_0_1_0_0;
            5'd2:    return 8'b00_0_0_1_0_1_0;
            5'd3:    return 8'b01_0_0_1_0_0_0;
            5'd4:    return 8'b10_0_0_1_0_1_0;
            5'd5:    return 8'b10_1_0_1_0_0_0;
            5'd6:    return 8'b10_0_1_1_0_1_0;
            5'd7:    return 8'b10_1_1_1_0_0_0;
            default: return 8'b00_0_0_0_0_0_1;
        endcase
    endfunction

    function automatic logic [7:0] dutCtrl();
        return {sel_a, sel_b, alu_op, wr_acc, wr_ram, rd_ram, illegal};
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        compared++;
        if (actual !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
        end
    endtask

    // Instruction-level model: each instruction takes a fetch step then an
    // execute step; HLT freezes everything, others advance the PC mod 2048.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            modelPc     = 0;
            modelExec   = 1'b0;
            modelHalted = 1'b0;
        end else if (enable && !modelHalted) begin
            if (modelExec) begin
                if (pm_data[15:11] == 5'd0) modelHalted = 1'b1;
                else                        modelPc = (modelPc + 1) % 2048;
                modelExec = 1'b0;
            end else begin
                modelExec = 1'b1;
            end
        end
    end

    always @(negedge clk) begin
        modelCtrl = (modelExec && enable && !modelHalted) ? expCtrl(pm_data[15:11]) : 8'h00;
        checkOutput("model strobes", {24'h0, dutCtrl()}, {24'h0, modelCtrl});
        checkOutput("model pm_addr", {21'h0, pm_addr}, 32'(modelPc));
        checkOutput("model halted", {31'h0, halted}, {31'h0, modelHalted});
        checkOutput("model operand", {21'h0, operand}, {21'h0, pm_data[10:0]});
    end

    // Advance n clock cycles; inputs change 2 time units after the edge.
    task automatic applyStimulus(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic startProgram();
        rst_n  = 1'b0;
        enable = 1'b1;
        for (int i = 0; i < 2048; i++) mem[i] = 16'h0000;
    endtask

    // Leaves the bench in cycle 0 (first FETCH) after reset release.
    task automatic releaseReset();
        @(posedge clk);
        @(posedge clk);
        #2;
        rst_n = 1'b1;
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [7:0] sweepExp [0:5];
        logic [10:0] wrapExp [0:5];
        int pulses;

        for (int i = 0; i < 2048; i++) mem[i] = 16'h0000;
        mem2[0] = ins(OP_LDI, 1);
        mem2[1] = ins(OP_ADDI, 1);
        mem2[2] = ins(OP_ADDI, 1);
        mem2[3] = ins(OP_ADDI, 1);

        // Reset and first instruction
        startProgram();
        mem[0] = ins(OP_LDI, 3);
        @(negedge clk);
        checkOutput("reset pm_addr", {21'h0, pm_addr}, 32'd0);
        checkOutput("reset strobes", {24'h0, dutCtrl()}, 32'd0);
        checkOutput("reset halted", {31'h0, halted}, 32'd0);
        releaseReset();
        @(negedge clk);
        checkOutput("first fetch pm_addr", {21'h0, pm_addr}, 32'd0);
        applyStimulus(1);
        @(negedge clk);
        checkOutput("ldi sel_a", {30'h0, sel_a}, 32'd1);
        checkOutput("ldi wr_acc", {31'h0, wr_acc}, 32'd1);
        checkOutput("ldi operand", {21'h0, operand}, 32'd3);
        applyStimulus(1);
        @(negedge clk);
        checkOutput("second fetch pm_addr", {21'h0, pm_addr}, 32'd1);

        // Opcode sweep
        startProgram();
        mem[0] = ins(OP_STO, 1);
        mem[1] = ins(OP_LD, 1);
        mem[2] = ins(OP_ADD, 1);
        mem[3] = ins(OP_ADDI, 4);
        mem[4] = ins(OP_SUB, 1);
        mem[5] = ins(OP_SUBI, 2);
        sweepExp[0] = 8'b00000100;
        sweepExp[1] = 8'b00001010;
        sweepExp[2] = 8'b10001010;
        sweepExp[3] = 8'b10101000;
        sweepExp[4] = 8'b10011010;
        sweepExp[5] = 8'b10111000;
        releaseReset();
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            checkOutput("sweep pm_addr", {21'h0, pm_addr}, 32'(k));
            applyStimulus(1);
            @(negedge clk);
            checkOutput("sweep strobes", {24'h0, dutCtrl()}, {24'h0, sweepExp[k]});
            applyStimulus(1);
        end

        // HLT at address 3, then reset while halted
        startProgram();
        mem[0] = ins(OP_LDI, 1);
        mem[1] = ins(OP_ADDI, 2);
        mem[2] = ins(OP_STO, 5);
        mem[3] = ins(OP_HLT, 0);
        releaseReset();
        applyStimulus(7);
        @(negedge clk);
        checkOutput("hlt exec halted", {31'h0, halted}, 32'd0);
        applyStimulus(1);
        @(negedge clk);
        checkOutput("halted rises", {31'h0, halted}, 32'd1);
        checkOutput("halt pm_addr", {21'h0, pm_addr}, 32'd3);
        for (int k = 0; k < 20; k++) begin
            applyStimulus(1);
            @(negedge clk);
            checkOutput("halt hold halted", {31'h0, halted}, 32'd1);
            checkOutput("halt hold pm_addr", {21'h0, pm_addr}, 32'd3);
            checkOutput("halt hold strobes", {24'h0, dutCtrl()}, 32'd0);
        end
        #3;
        rst_n = 1'b0;
        #1;
        checkOutput("async reset halted", {31'h0, halted}, 32'd0);
        checkOutput("async reset pm_addr", {21'h0, pm_addr}, 32'd0);

        // Stall during EXEC of ADDI 4
        startProgram();
        mem[0] = ins(OP_LDI, 1);
        mem[1] = ins(OP_ADDI, 4);
        releaseReset();
        applyStimulus(3);
        enable = 1'b0;
        pulses = 0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            pulses += int'(wr_acc);
            checkOutput("stall strobes", {24'h0, dutCtrl()}, 32'd0);
            checkOutput("stall pm_addr", {21'h0, pm_addr}, 32'd1);
            applyStimulus(1);
        end
        enable = 1'b1;
        @(negedge clk);
        pulses += int'(wr_acc);
        checkOutput("reenable strobes", {24'h0, dutCtrl()}, 32'b10101000);
        applyStimulus(1);
        @(negedge clk);
        pulses += int'(wr_acc);
        checkOutput("reenable pm_addr", {21'h0, pm_addr}, 32'd2);
        checkOutput("stall wr_acc pulses", 32'(pulses), 32'd1);

        // Illegal opcode acts as a flagged NOP
        startProgram();
        mem[0] = ins(OP_LDI, 7);
        mem[1] = 16'hF805;
        mem[2] = ins(OP_LDI, 9);
        releaseReset();
        applyStimulus(3);
        @(negedge clk);
        checkOutput("illegal flag", {31'h0, illegal}, 32'd1);
        checkOutput("illegal no writes", {29'h0, wr_acc, wr_ram, rd_ram}, 32'd0);
        checkOutput("illegal operand", {21'h0, operand}, 32'd5);
        applyStimulus(1);
        @(negedge clk);
        checkOutput("illegal pc advance", {21'h0, pm_addr}, 32'd2);
        checkOutput("illegal one pulse", {31'h0, illegal}, 32'd0);

        // PC wrap on the PROG_DEPTH=4 instance
        startProgram();
        wrapExp[0] = 11'd0;
        wrapExp[1] = 11'd1;
        wrapExp[2] = 11'd2;
        wrapExp[3] = 11'd3;
        wrapExp[4] = 11'd0;
        wrapExp[5] = 11'd1;
        releaseReset();
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            checkOutput("wrap pm_addr", {21'h0, pm_addr2}, {21'h0, wrapExp[k]});
            applyStimulus(2);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
